// File: rtl/_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with occupancy count, full/empty
// decoded from the count, and sticky overflow/underflow error flags.
module _fifo_sync #(
    parameter int n     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [n-1:0]  wr_data,
    input  logic          rd_en,
    output logic [n-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    logic [n-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // A push into a full FIFO is still accepted when the same edge pops,
    // because the write lands in the slot being vacated.
    assign push_ok = wr_en && (!full || rd_en);
    assign pop_ok  = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (wr_en && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not cleared by reset; empty masks stale entries.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb__fifo_sync.sv
// Directed bench for _fifo_sync (16-bit words, 4 entries): reset, fill/drain,
// error flags, boundary simultaneous push/pop, wrap-around and mid-run reset.
module tb__fifo_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        underflow;

    int unsigned tests = 0;
    int unsigned failed = 0;

    _fifo_sync #(.n(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance past the edge, then return to idle.
    task automatic step(input logic r, input logic w, input logic [15:0] d, input logic p);
        rst     = r;
        wr_en   = w;
        wr_data = d;
        rd_en   = p;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset with push/pop requested: both must be ignored
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h0000);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        // Fill
        step(1'b0, 1'b1, 16'h0011, 1'b0);
        chk("fill1_count", 32'(count), 32'd1);
        chk("fill1_empty", 32'(empty), 32'd0);
        chk("fill1_rd_data", 32'(rd_data), 32'h0011);
        step(1'b0, 1'b1, 16'h0022, 1'b0);
        chk("fill2_count", 32'(count), 32'd2);
        step(1'b0, 1'b1, 16'h0033, 1'b0);
        chk("fill3_count", 32'(count), 32'd3);
        chk("fill3_full", 32'(full), 32'd0);
        step(1'b0, 1'b1, 16'h0044, 1'b0);
        chk("fill4_count", 32'(count), 32'd4);
        chk("fill4_full", 32'(full), 32'd1);
        chk("fill4_rd_data", 32'(rd_data), 32'h0011);

        // Overflow: rejected push leaves contents alone
        step(1'b0, 1'b1, 16'h0055, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_underflow", 32'(underflow), 32'd0);
        chk("ovf_rd_data", 32'(rd_data), 32'h0011);

        // Drain
        chk("drain_0011", 32'(rd_data), 32'h0011);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("drain_0022", 32'(rd_data), 32'h0022);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("drain_0033", 32'(rd_data), 32'h0033);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("drain_0044", 32'(rd_data), 32'h0044);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rd_data", 32'(rd_data), 32'h0000);
        chk("drain_count", 32'(count), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Underflow
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_empty", 32'(empty), 32'd1);

        step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("rst2_overflow", 32'(overflow), 32'd0);
        chk("rst2_underflow", 32'(underflow), 32'd0);

        // Simultaneous push+pop while full
        step(1'b0, 1'b1, 16'h00A1, 1'b0);
        step(1'b0, 1'b1, 16'h00A2, 1'b0);
        step(1'b0, 1'b1, 16'h00A3, 1'b0);
        step(1'b0, 1'b1, 16'h00A4, 1'b0);
        chk("fullpp_pre_full", 32'(full), 32'd1);
        step(1'b0, 1'b1, 16'h00A5, 1'b1);
        chk("fullpp_rd_data", 32'(rd_data), 32'h00A2);
        chk("fullpp_count", 32'(count), 32'd4);
        chk("fullpp_overflow", 32'(overflow), 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("fullpp_A3", 32'(rd_data), 32'h00A3);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("fullpp_A4", 32'(rd_data), 32'h00A4);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("fullpp_A5", 32'(rd_data), 32'h00A5);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("fullpp_empty", 32'(empty), 32'd1);
        chk("fullpp_underflow", 32'(underflow), 32'd0);

        // Simultaneous push+pop while empty
        step(1'b0, 1'b1, 16'h00B1, 1'b1);
        chk("emptypp_count", 32'(count), 32'd1);
        chk("emptypp_rd_data", 32'(rd_data), 32'h00B1);
        chk("emptypp_underflow", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("emptypp_drained", 32'(empty), 32'd1);

        // Wrap-around: steady push+pop at occupancy 2
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'd1, 1'b0);
        step(1'b0, 1'b1, 16'd2, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            chk("wrap_head", 32'(rd_data), 32'(i));
            step(1'b0, 1'b1, 16'(i + 2), 1'b1);
            chk("wrap_count", 32'(count), 32'd2);
        end
        chk("wrap_tail11", 32'(rd_data), 32'd11);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("wrap_tail12", 32'(rd_data), 32'd12);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_flags", 32'({overflow, underflow}), 32'd0);

        // Reset mid-operation with a push request
        step(1'b0, 1'b1, 16'h00C1, 1'b0);
        step(1'b0, 1'b1, 16'h00C2, 1'b0);
        step(1'b0, 1'b1, 16'h00C3, 1'b0);
        chk("midrst_pre_count", 32'(count), 32'd3);
        step(1'b1, 1'b1, 16'h0099, 1'b0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_rd_data", 32'(rd_data), 32'h0000);
        step(1'b0, 1'b1, 16'h0077, 1'b0);
        chk("midrst_first", 32'(rd_data), 32'h0077);
        chk("midrst_count1", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/_fifo_sync.md
Name: _fifo_sync

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO. It is the buffered reader side paired with the register/flip-flop writer primitives in src/utils.
- Decouples a producer stage (for example, a memory/fetch return path) from a consumer stage (for example, decode) that may stall.
- Holds up to DEPTH words of n bits. Reports occupancy, full, empty and sticky overflow/underflow errors.

Parameters:
- n, constants::WORD_LENGTH, width of each data word in bits.
- DEPTH, 4, number of entries. Must be a power of two and at least 2.
- AW, $clog2(DEPTH), pointer width. Derived; never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- wr_en  input  1  push request.
- wr_data  input  n  push data.
- rd_en  input  1  pop request.
- rd_data  output  n  head entry; valid whenever empty=0.
- full  output  1  occupancy equals DEPTH.
- empty  output  1  occupancy equals 0.
- count  output  AW+1  current occupancy, from 0 to DEPTH.
- overflow  output  1  sticky; set by a push attempt that is rejected.
- underflow  output  1  sticky; set by a pop attempt that is rejected.

Behaviour:
- Reset:
  - rst=1 at a rising edge sets wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, rd_data=0.
  - Storage array is not cleared.
  - rst has priority over wr_en/rd_en in the same cycle. A push or pop requested during a reset cycle has no effect.
  - Reset mid-operation discards all contents.
- Push: accepted when wr_en=1 and (full=0, or full=1 with rd_en=1). Writes mem[wr_ptr]=wr_data, then wr_ptr increments modulo DEPTH.
- Pop: accepted when rd_en=1 and empty=0. rd_ptr increments modulo DEPTH.
- FWFT read path:
  - rd_data = mem[rd_ptr] combinationally while empty=0; rd_data = 0 while empty=1.
  - No read latency: data popped in cycle t is the data visible on rd_data during cycle t.
  - Write-to-read latency: a word pushed into an empty FIFO at edge t appears on rd_data after edge t, with empty=0 from that point.
- Count update per edge: count + push_accepted - pop_accepted. full and empty are decoded from count, never from pointer comparison.
- Simultaneous events:
  - full and wr_en=1, rd_en=1: both are accepted and count stays at DEPTH. The new word lands in the slot freed by the pop (wr_ptr == rd_ptr before the edge).
  - empty and wr_en=1, rd_en=1: the push is accepted and the pop is rejected. count becomes 1 and underflow is set.
  - Otherwise non-boundary: both are accepted and count is unchanged.
- Error flags:
  - overflow is set on any edge with wr_en=1 and push rejected.
  - underflow is set on any edge with rd_en=1 and empty=1.
  - Both hold until rst.
  - A rejected operation changes no pointer, count or storage.
- Wrap-around: pointers wrap silently from DEPTH-1 to 0. Data order is preserved across wrap.
- No X is allowed on any output after the first reset edge.

Test Plan:
- Reset/idle (n=16, DEPTH=4): assert rst for 2 edges with wr_en=rd_en=1 and wr_data=16'hFFFF -> count=0, empty=1, full=0, rd_data=16'h0000, overflow=underflow=0.
- Fill and drain:
  - Push 16'h0011, 16'h0022, 16'h0033, 16'h0044 on 4 consecutive edges -> count=1,2,3,4; full=1 after the 4th edge; rd_data=16'h0011 after the 1st edge.
  - Pop 4 times -> rd_data sequence 0011, 0022, 0033, 0044; then empty=1 and rd_data=0.
- Overflow/underflow:
  - When full, push 16'h0055 with rd_en=0 -> contents unchanged and overflow=1 (stays 1).
  - When empty, pop -> underflow=1 and count stays 0.
- Simultaneous at boundaries:
  - Full [A1,A2,A3,A4], push 16'h00A5 + pop -> rd_data=A2, count=4; later drain order is A2, A3, A4, A5.
  - Empty, push 16'h00B1 + pop -> count=1, rd_data=00B1, underflow=1.
- Wrap-around: 10 cycles of steady push+pop at count=2 with incrementing data 1..10 -> pops emerge in order with no loss or duplication; pointers wrap at least twice.
- Reset mid-operation: count=3, assert rst together with wr_en=1 -> next cycle count=0, empty=1; push 16'h0077 then reads back 0077 first.
